// File: rtl/fp_adder_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fp_arb_pkg
// Shared definitions for the floating-point adder arbiter: FSM state encoding,
// timing constants and the round-robin pick function used by rr_arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package fp_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } arb_state_t;

    // Cycles the adder gets to drop 'done' after 'start' before we give up.
    localparam int BUSY_WAIT_MAX   = 4;
    localparam int DEFAULT_TIMEOUT = 64;

    // The pick function works on a fixed 8-wide vector; callers zero-extend.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Search order is ptr, ptr+1, ... wrapping at n_req; the first set bit
    // wins. Iterating from the far end and overwriting leaves the nearest
    // hit in 'pick' without needing a loop break.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 n_req);
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n_req) begin
                idx = int'(ptr) + k;
                if (idx >= n_req) begin
                    idx = idx - n_req;
                end
                if (req[idx]) begin
                    pick.found = 1'b1;
                    pick.idx   = IDX_W'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick among N_REQ requesters starting at 'ptr'.
// Ports:
//   req   in   N_REQ  request vector
//   ptr   in   PW     highest-priority index for this pick
//   win   out  PW     winning index (valid when found=1)
//   found out  1      at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    win,
    output logic             found
);

    rr_pick_t pick;

    // NOTE: every variable assigned in always_comb gets a value on every
    // path, otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        pick  = rr_pick(MAX_REQ'(req), IDX_W'(ptr), N_REQ);
        win   = PW'(pick.idx);
        found = pick.found;
    end

endmodule

// File: rtl/fp_adder_arbiter.sv
// -----------------------------------------------------------------------------
// fp_adder_arbiter
// Shares one floating-point adder between N_REQ requesters. A round-robin
// winner is granted, its operands are registered to the adder, the adder's
// start/done handshake is driven, and the sum is returned with a one-cycle
// resp_valid pulse. A watchdog aborts operations the adder never starts or
// never finishes.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   req      in  N_REQ        per-requester request, held until gnt
//   op_a     in  N_REQ*WIDTH  operand A, slice i belongs to requester i
//   op_b     in  N_REQ*WIDTH  operand B, same packing
//   gnt      out N_REQ        one-hot grant pulse (operands captured)
//   resp_valid out N_REQ      one-hot response pulse, result valid
//   result   out WIDTH        last sum, held until next response
//   timeout_err out 1         watchdog abort pulse
//   busy     out 1            high in every state but IDLE
//   add_start out 1           adder start pulse
//   add_a, add_b out WIDTH    registered adder operands
//   add_done in  1            adder done / idle indication
//   add_result in WIDTH       adder sum
// -----------------------------------------------------------------------------
module fp_adder_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]       result,
    output logic                   timeout_err,
    output logic                   busy,
    output logic                   add_start,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic                   add_done,
    input  logic [WIDTH-1:0]       add_result
);

    localparam int PW     = $clog2(N_REQ);
    // Shared by the WAIT_BUSY and WAIT_DONE counts; wide enough for both.
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 3) ? CW_RAW : 3;

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    next_ptr;
    logic [PW-1:0]    win;
    logic             found;
    logic [CW-1:0]    wd_cnt;
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] owner_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr),
        .win   (win),
        .found (found)
    );

    always_comb begin
        win_onehot          = '0;
        win_onehot[win]     = 1'b1;
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
        // Pointer moves past the owner whether the operation completed or
        // was aborted, so a broken requester cannot monopolise the adder.
        next_ptr = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            wd_cnt      <= '0;
            gnt         <= '0;
            resp_valid  <= '0;
            timeout_err <= 1'b0;
            add_start   <= 1'b0;
            result      <= '0;
            add_a       <= '0;
            add_b       <= '0;
        end else begin
            // Pulse outputs default low so each is high for one cycle at most.
            gnt         <= '0;
            resp_valid  <= '0;
            timeout_err <= 1'b0;
            add_start   <= 1'b0;

            case (state)
                IDLE: begin
                    // add_done=1 means the adder is idle and can take work.
                    if (found && add_done) begin
                        gnt   <= win_onehot;
                        add_a <= op_a[win*WIDTH +: WIDTH];
                        add_b <= op_b[win*WIDTH +: WIDTH];
                        owner <= win;
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    add_start <= 1'b1;
                    wd_cnt    <= '0;
                    state     <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    // The adder must drop done to show it accepted start;
                    // until then a rising done cannot be trusted as a result.
                    if (!add_done) begin
                        wd_cnt <= '0;
                        state  <= WAIT_DONE;
                    end else if (wd_cnt == CW'(BUSY_WAIT_MAX - 1)) begin
                        timeout_err <= 1'b1;
                        ptr         <= next_ptr;
                        wd_cnt      <= '0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (add_done) begin
                        result <= add_result;
                        wd_cnt <= '0;
                        state  <= RESP;
                    end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        ptr         <= next_ptr;
                        wd_cnt      <= '0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                RESP: begin
                    resp_valid <= owner_onehot;
                    ptr        <= next_ptr;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

Round-robin scheduler that shares one floating-point adder between `N_REQ` requesters. Captures the winning requester's operands, drives the adder's `start`/`done` handshake, and returns the sum to the granted requester with a one-cycle valid pulse. Sits between requester ports and the adder top level. A watchdog aborts a hung operation.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 32: operand/result width (IEEE-754 single).
- `TIMEOUT`, default 64: maximum cycles allowed in `WAIT_DONE`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester request; held high until the matching `gnt` bit.
- `op_a`  in  N_REQ*WIDTH  operand A; slice i belongs to requester i.
- `op_b`  in  N_REQ*WIDTH  operand B, same packing.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse; operands captured on this cycle.
- `resp_valid`  out  N_REQ  one-hot, one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  last sum, held until the next response.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.
- `busy`  out  1  high in every state except `IDLE`.
- `add_start`  out  1  to adder `start`.
- `add_a`, `add_b`  out  WIDTH  registered operands to the adder.
- `add_done`  in  1  from adder `done`; high while the adder is idle.
- `add_result`  in  WIDTH  adder sum.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`, `RESP`.
- `IDLE`: if any `req` is high and `add_done` is 1:
  - Pick the winner by round-robin from pointer `ptr`.
  - Pulse `gnt[win]`.
  - Register `add_a`/`add_b` from slice `win` and latch `owner=win`.
  - Go to `ISSUE`.
  - Otherwise stay in `IDLE`.
- `ISSUE`: `add_start=1` for exactly one cycle, then go to `WAIT_BUSY`.
- `WAIT_BUSY`: wait for `add_done=0`, meaning the adder has left its idle state, then go to `WAIT_DONE`.
  - If `add_done` is still 1 after 4 cycles, pulse `timeout_err` and go to `IDLE` (adder never started).
- `WAIT_DONE`: the watchdog counter increments each cycle.
  - On `add_done=1`: register `result<=add_result`, go to `RESP`.
  - If the counter reaches `TIMEOUT-1` without `add_done`: pulse `timeout_err`, go to `IDLE`. No `resp_valid` is produced and `ptr` still advances.
- `RESP`: pulse `resp_valid[owner]`, set `ptr <= (owner+1) mod N_REQ`, go to `IDLE`.
- Round-robin: search order is `ptr, ptr+1, …` wrapping mod `N_REQ`; the first asserted `req` wins. There is no starvation; the worst-case wait is `N_REQ-1` operations.
- `add_a`/`add_b` are stable from `ISSUE` through `WAIT_DONE`; the adder samples them in its load cycle.
- `req` dropping after `gnt` has no effect. A `req` dropping before grant is simply not considered.
- Reset values:
  - state `IDLE`, `ptr=0`, `owner=0`, watchdog 0.
  - `gnt=0`, `resp_valid=0`, `timeout_err=0`, `add_start=0`, `busy=0`.
  - `result=0`, `add_a=0`, `add_b=0`.
- Reset mid-operation: everything returns to reset values immediately. An in-flight requester receives no response and must re-request.

## Timing
- Grant to `add_start`: 1 cycle.
- `add_done` rising to `resp_valid`: 2 cycles (register in `WAIT_DONE`→`RESP`, pulse in `RESP`).
- Back-to-back: next `gnt` earliest in the cycle after `RESP`, and only if `add_done=1`.
- `gnt`, `resp_valid`, `timeout_err` and `add_start` are registered outputs, never high for more than 1 cycle.
- `busy` is combinational from state.

## Structure
- Shared package `fp_arb_pkg`:
  - State enum `arb_state_t`.
  - Constants `BUSY_WAIT_MAX=4` and the default `TIMEOUT`.
  - Function `rr_pick(req, ptr)` returning index and found flag.
- One sub-module: `rr_arbiter` (combinational round-robin pick with `N_REQ` parameter), instanced once. The FSM and registers live in the top.

## Test plan
- Single request, `req=0001`, A=0x3F800000, B=0x40000000, adder model done after 10 cycles -> `gnt=0001`, `resp_valid=0001`, `result=0x40400000`, `ptr=1`.
- All four `req` high from reset, operands held -> grants in order 0,1,2,3,0, each `resp_valid` matching its grant; no grant while `busy=1`.
- `ptr=2`, `req=1001` -> requester 3 granted first, then 0.
- Adder model never raises `done` -> `timeout_err` pulses at `TIMEOUT` cycles into `WAIT_DONE`, no `resp_valid`, FSM back in `IDLE`, next request serviced normally.
- Adder model keeps `done=1` after `start` -> `timeout_err` after 4 cycles in `WAIT_BUSY`.
- `rst_n` low during `WAIT_DONE` -> all outputs at reset values in the same cycle; after release, `req=0100` gets `gnt=0100` and `ptr` restarts from 0.
